// File: rtl/pio_cfg_loader.sv
// pio_cfg_loader: replays preloaded program words and per-machine settings onto the pio action bus
module pio_cfg_loader #(
  parameter int NUM_SM = 4,
  parameter int PROG_DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_we,
  input  logic [6:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [3:0]  action,
  output logic [4:0]  index,
  output logic [1:0]  mindex,
  output logic [31:0] din
);
  localparam int AW = PROG_DEPTH > 1 ? $clog2(PROG_DEPTH) : 1;
  localparam logic [3:0] A_NONE = 4'd0, A_INSTR = 4'd1, A_PEND = 4'd2, A_GRPS = 4'd5, A_EN = 4'd6, A_DIV = 4'd7;
  typedef enum logic [2:0] {IDLE, INSTR, CFG, ENA, FIN} state_t;
  state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d, plen_q, plen_d, plen_eff, nxt_i;
  logic [1:0] m_q, m_d, ph_q, ph_d, wm;
  logic [NUM_SM-1:0] en_mask_q, en_mask_d;
  logic [4:0] pend_q [4], pend_d [4];
  logic [23:0] div_q [4], div_d [4];
  logic [31:0] grps_q [4], grps_d [4];
  logic [15:0] prog_q [PROG_DEPTH], prog_d [PROG_DEPTH];
  logic busy_q, busy_d, done_q, done_d, wr, try_i, try_c, try_e;
  logic [3:0] action_q, action_d;
  logic [4:0] index_q, index_d;
  logic [1:0] mindex_q, mindex_d;
  logic [31:0] din_q, din_d;
  logic [2:0] c_from, e_from, c_hit, e_hit;
  // lowest enabled machine at or above 'from'; 4 means none
  function automatic logic [2:0] first_en(input logic [3:0] msk, input logic [2:0] from);
    first_en = 3'd4;
    for (int k = 3; k >= 0; k--) if (msk[k] && 3'(k) >= from) first_en = 3'(k);
  endfunction
  always_comb begin
    wr = cfg_we && !busy_q;
    wm = cfg_addr[3:2];
    prog_d = prog_q;
    plen_d = plen_q;
    en_mask_d = en_mask_q;
    pend_d = pend_q;
    div_d = div_q;
    grps_d = grps_q;
    if (wr && int'(cfg_addr) < PROG_DEPTH) prog_d[cfg_addr[AW-1:0]] = cfg_wdata[15:0];
    if (wr && cfg_addr == 7'h20) plen_d = cfg_wdata[5:0];
    if (wr && cfg_addr == 7'h21) en_mask_d = cfg_wdata[NUM_SM-1:0];
    if (wr && cfg_addr[6:4] == 3'b100 && int'(wm) < NUM_SM) begin
      if (cfg_addr[1:0] == 2'd0) pend_d[wm] = cfg_wdata[4:0];
      if (cfg_addr[1:0] == 2'd1) div_d[wm] = cfg_wdata[23:0];
      if (cfg_addr[1:0] == 2'd2) grps_d[wm] = cfg_wdata;
    end
    plen_eff = int'(plen_d) > PROG_DEPTH ? 6'(PROG_DEPTH) : plen_d;
  end
  // same-cycle writes are visible through the _d values, so start sees fresh config
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    m_d = m_q;
    ph_d = ph_q;
    nxt_i = cnt_q + 6'd1;
    try_i = 1'b0;
    try_c = 1'b0;
    try_e = 1'b0;
    c_from = 3'd0;
    e_from = 3'd0;
    case (state_q)
      IDLE: begin
        try_i = start;
        nxt_i = 6'd0;
      end
      INSTR: try_i = 1'b1;
      CFG: begin
        if (ph_q != 2'd2) ph_d = ph_q + 2'd1;
        else begin
          try_c = 1'b1;
          c_from = {1'b0, m_q} + 3'd1;
        end
      end
      ENA: begin
        try_e = 1'b1;
        e_from = {1'b0, m_q} + 3'd1;
      end
      default: state_d = IDLE;
    endcase
    if (try_i && nxt_i >= plen_eff) begin
      try_i = 1'b0;
      try_c = 1'b1;
    end
    c_hit = first_en(4'(en_mask_d), c_from);
    if (try_c && c_hit[2]) begin
      try_c = 1'b0;
      try_e = 1'b1;
    end
    e_hit = first_en(4'(en_mask_d), e_from);
    if (try_i) begin
      state_d = INSTR;
      cnt_d = nxt_i;
    end
    if (try_c) begin
      state_d = CFG;
      m_d = c_hit[1:0];
      ph_d = 2'd0;
    end
    if (try_e) begin
      state_d = e_hit[2] ? FIN : ENA;
      m_d = e_hit[1:0];
    end
  end
  always_comb begin
    action_d = A_NONE;
    index_d = 5'd0;
    mindex_d = 2'd0;
    din_d = 32'd0;
    done_d = state_d == FIN;
    busy_d = state_d == INSTR || state_d == CFG || state_d == ENA;
    if (state_d == INSTR) begin
      action_d = A_INSTR;
      index_d = cnt_d[4:0];
      din_d = {16'd0, prog_d[cnt_d[AW-1:0]]};
    end
    if (state_d == CFG) begin
      mindex_d = m_d;
      action_d = ph_d == 2'd0 ? A_PEND : ph_d == 2'd1 ? A_DIV : A_GRPS;
      din_d = ph_d == 2'd0 ? {27'd0, pend_d[m_d]} : ph_d == 2'd1 ? {8'd0, div_d[m_d]} : grps_d[m_d];
    end
    if (state_d == ENA) begin
      mindex_d = m_d;
      action_d = A_EN;
      din_d = 32'd1;
    end
  end
  always_ff @(posedge clk) prog_q <= prog_d;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      m_q <= '0;
      ph_q <= '0;
      plen_q <= '0;
      en_mask_q <= '0;
      pend_q <= '{default: '0};
      div_q <= '{default: '0};
      grps_q <= '{default: '0};
      busy_q <= 1'b0;
      done_q <= 1'b0;
      action_q <= A_NONE;
      index_q <= '0;
      mindex_q <= '0;
      din_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      m_q <= m_d;
      ph_q <= ph_d;
      plen_q <= plen_d;
      en_mask_q <= en_mask_d;
      pend_q <= pend_d;
      div_q <= div_d;
      grps_q <= grps_d;
      busy_q <= busy_d;
      done_q <= done_d;
      action_q <= action_d;
      index_q <= index_d;
      mindex_q <= mindex_d;
      din_q <= din_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign action = action_q;
  assign index = index_q;
  assign mindex = mindex_q;
  assign din = din_q;
endmodule

// File: tb/tb_pio_cfg_loader.sv
// tb_pio_cfg_loader: scoreboard bench driving a 4-machine/32-slot and a 1-machine/8-slot loader from shared inputs
module tb_pio_cfg_loader;
  typedef struct packed {
    logic [3:0] act;
    logic [4:0] idx;
    logic [1:0] mi;
    logic [31:0] din;
    logic busy;
    logic done;
  } ev_t;
  logic clk = 1'b0, reset = 1'b0, cfg_we = 1'b0, start = 1'b0, mon_en = 1'b0;
  logic [6:0] cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic [1:0] busy, done;
  logic [1:0][3:0] action;
  logic [1:0][4:0] index;
  logic [1:0][1:0] mindex;
  logic [1:0][31:0] din;
  int vectors = 0, miscompares = 0;
  int busy_cnt [2], exp_busy [2];
  ev_t exp_q [2][$];
  ev_t o_v, e_v;
  logic [15:0] m_prog [2][32];
  logic [5:0] m_plen [2];
  logic [3:0] m_mask [2];
  logic [4:0] m_pend [2][4];
  logic [23:0] m_div [2][4];
  logic [31:0] m_grps [2][4];

  pio_cfg_loader u0 (.clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .start(start), .busy(busy[0]), .done(done[0]), .action(action[0]), .index(index[0]), .mindex(mindex[0]), .din(din[0]));
  pio_cfg_loader #(.NUM_SM(1), .PROG_DEPTH(8)) u1 (.clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .start(start), .busy(busy[1]), .done(done[1]), .action(action[1]), .index(index[1]),
    .mindex(mindex[1]), .din(din[1]));

  always #5 clk = ~clk;

  function automatic int nsm(input int d);
    return d == 0 ? 4 : 1;
  endfunction
  function automatic int pd(input int d);
    return d == 0 ? 32 : 8;
  endfunction
  function automatic ev_t mk(input logic [3:0] a, input int i, input int m, input logic [31:0] dv, input logic b, input logic dn);
    return '{a, 5'(i), 2'(m), dv, b, dn};
  endfunction
  function automatic string fmt(input ev_t v);
    return $sformatf("act=%0d idx=%0d mi=%0d din=%08h busy=%0b done=%0b", v.act, v.idx, v.mi, v.din, v.busy, v.done);
  endfunction
  function automatic ev_t obs(input int d);
    return {action[d], index[d], mindex[d], din[d], busy[d], done[d]};
  endfunction

  task automatic mdl_reset();
    for (int d = 0; d < 2; d++) begin
      m_plen[d] = '0;
      m_mask[d] = '0;
      for (int m = 0; m < 4; m++) begin
        m_pend[d][m] = '0;
        m_div[d][m] = '0;
        m_grps[d][m] = '0;
      end
    end
  endtask

  task automatic mdl_write(input logic [6:0] a, input logic [31:0] w);
    int m, j;
    m = (int'(a) - 64) / 4;
    j = (int'(a) - 64) % 4;
    for (int d = 0; d < 2; d++) begin
      if (int'(a) < pd(d)) m_prog[d][a[4:0]] = w[15:0];
      else if (a == 7'h20) m_plen[d] = w[5:0];
      else if (a == 7'h21) m_mask[d] = w[3:0] & (nsm(d) == 4 ? 4'hF : 4'((1 << nsm(d)) - 1));
      else if (int'(a) >= 64 && int'(a) < 80 && m < nsm(d)) begin
        if (j == 0) m_pend[d][m] = w[4:0];
        if (j == 1) m_div[d][m] = w[23:0];
        if (j == 2) m_grps[d][m] = w;
      end
    end
  endtask

  task automatic expect_run(input int d);
    int peff;
    peff = int'(m_plen[d]);
    if (peff > pd(d)) peff = pd(d);
    for (int i = 0; i < peff; i++) exp_q[d].push_back(mk(4'd1, i, 0, {16'd0, m_prog[d][i]}, 1'b1, 1'b0));
    for (int m = 0; m < 4; m++)
      if (m_mask[d][m]) begin
        exp_q[d].push_back(mk(4'd2, 0, m, {27'd0, m_pend[d][m]}, 1'b1, 1'b0));
        exp_q[d].push_back(mk(4'd7, 0, m, {8'd0, m_div[d][m]}, 1'b1, 1'b0));
        exp_q[d].push_back(mk(4'd5, 0, m, m_grps[d][m], 1'b1, 1'b0));
      end
    for (int m = 0; m < 4; m++) if (m_mask[d][m]) exp_q[d].push_back(mk(4'd6, 0, m, 32'd1, 1'b1, 1'b0));
    exp_q[d].push_back(mk(4'd0, 0, 0, 32'd0, 1'b0, 1'b1));
    exp_busy[d] = peff + 4 * $countones(m_mask[d]);
  endtask

  task automatic cfg_write(input logic [6:0] a, input logic [31:0] w, input bit mdl);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = w;
    @(posedge clk);
    #1 cfg_we = 1'b0;
    if (mdl) mdl_write(a, w);
  endtask

  task automatic run(input bit we, input logic [6:0] a, input logic [31:0] w, input bit inject);
    busy_cnt[0] = 0;
    busy_cnt[1] = 0;
    start = 1'b1;
    cfg_we = we;
    cfg_addr = a;
    cfg_wdata = w;
    @(posedge clk);
    #1 start = 1'b0;
    cfg_we = 1'b0;
    if (we) mdl_write(a, w);
    expect_run(0);
    expect_run(1);
    if (inject) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      cfg_we = 1'b1;
      cfg_addr = 7'h40;
      cfg_wdata = 32'h1F;
      @(posedge clk);
      #1 start = 1'b0;
      cfg_we = 1'b0;
    end
    for (int t = 0; t < 200 && (exp_q[0].size() != 0 || exp_q[1].size() != 0); t++) @(posedge clk);
    for (int d = 0; d < 2; d++)
      if (exp_q[d].size() != 0) begin
        miscompares++;
        $display("FAIL dut%0d timeout: %0d events still pending, want 0", d, exp_q[d].size());
        exp_q[d].delete();
      end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (busy_cnt[d] != exp_busy[d]) begin
        miscompares++;
        $display("FAIL dut%0d busy_cycles: got %0d, want %0d", d, busy_cnt[d], exp_busy[d]);
      end
    end
  endtask

  always @(negedge clk)
    if (mon_en)
      for (int d = 0; d < 2; d++) begin
        o_v = obs(d);
        vectors++;
        if (o_v.busy === 1'b1) busy_cnt[d]++;
        if (o_v.act !== 4'd0 || o_v.done !== 1'b0) begin
          if (exp_q[d].size() == 0) begin
            miscompares++;
            $display("FAIL dut%0d unexpected: got %s, want idle", d, fmt(o_v));
          end else begin
            e_v = exp_q[d].pop_front();
            if (o_v !== e_v) begin
              miscompares++;
              $display("FAIL dut%0d event: got %s, want %s", d, fmt(o_v), fmt(e_v));
            end
          end
        end else if (exp_q[d].size() != 0) begin
          miscompares++;
          $display("FAIL dut%0d gap: got %s, want %s", d, fmt(o_v), fmt(exp_q[d][0]));
        end else if (o_v !== '0) begin
          miscompares++;
          $display("FAIL dut%0d idle: got %s, want all zero", d, fmt(o_v));
        end
      end

  initial begin
    mdl_reset();
    repeat (3) @(posedge clk);
    #1 mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int a = 0; a < 32; a++) cfg_write(7'(a), $urandom, 1'b1);
    cfg_write(7'h00, 32'hE001, 1'b1);
    cfg_write(7'h01, 32'h0000, 1'b1);
    cfg_write(7'h20, 32'd2, 1'b1);
    cfg_write(7'h21, 32'd1, 1'b1);
    cfg_write(7'h40, 32'd1, 1'b1);
    cfg_write(7'h41, 32'h280, 1'b1);
    cfg_write(7'h42, 32'h04000000, 1'b1);
    run(1'b0, 7'h0, 32'h0, 1'b0);
    cfg_write(7'h20, 32'd0, 1'b1);
    cfg_write(7'h21, 32'hA, 1'b1);
    for (int a = 'h44; a < 'h50; a++) cfg_write(7'(a), $urandom, 1'b1);
    run(1'b0, 7'h0, 32'h0, 1'b0);
    cfg_write(7'h20, 32'd40, 1'b1);
    cfg_write(7'h21, 32'd1, 1'b1);
    run(1'b0, 7'h0, 32'h0, 1'b1);
    run(1'b0, 7'h0, 32'h0, 1'b0);
    cfg_write(7'h20, 32'd0, 1'b1);
    cfg_write(7'h21, 32'd0, 1'b1);
    run(1'b0, 7'h0, 32'h0, 1'b0);
    cfg_write(7'h21, 32'hF, 1'b1);
    for (int a = 'h44; a < 'h4F; a++) cfg_write(7'(a), $urandom, 1'b1);
    run(1'b0, 7'h0, 32'h0, 1'b0);
    run(1'b1, 7'h20, 32'd5, 1'b0);
    cfg_write(7'h20, 32'd5, 1'b1);
    cfg_write(7'h21, 32'd3, 1'b1);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    expect_run(0);
    expect_run(1);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    exp_q[0].delete();
    exp_q[1].delete();
    mdl_reset();
    repeat (8) @(posedge clk);
    #1;
    run(1'b0, 7'h0, 32'h0, 1'b0);
    for (int r = 0; r < 20; r++) begin
      repeat ($urandom_range(1, 6)) cfg_write(7'($urandom_range(0, 31)), $urandom, 1'b1);
      cfg_write(7'h20, 32'($urandom_range(0, 40)), 1'b1);
      cfg_write(7'h21, $urandom, 1'b1);
      repeat (4) cfg_write(7'($urandom_range('h40, 'h4F)), $urandom, 1'b1);
      cfg_write($urandom_range(0, 1) ? 7'($urandom_range('h22, 'h3F)) : 7'($urandom_range('h50, 'h7F)), $urandom, 1'b1);
      if ($urandom_range(0, 3) == 0) run(1'b1, 7'h21, $urandom, 1'b0);
      else run(1'b0, 7'h0, 32'h0, 1'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pio_cfg_loader.md
# pio_cfg_loader

Synthesizable configuration sequencer for the `pio` block. It generalises the bench-side bring-up sequence into hardware for up to four state machines. A host preloads the program words and the per-machine settings through a simple register write port. A `start` pulse then makes the loader replay them onto the `pio` action bus (`action`/`index`/`mindex`/`din`), one action per clock, and enable the selected machines.

## Interface
Parameters:
- `NUM_SM`, default 4: number of state machines sequenced; legal range 1..4.
- `PROG_DEPTH`, default 32: number of program slots; legal range 1..32.

Ports:
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-low reset, sampled on the `clk` rising edge.
- `cfg_we`  in  1  host write strobe.
- `cfg_addr`  in  7  host register address (see Operation).
- `cfg_wdata`  in  32  host write data.
- `start`  in  1  single-cycle pulse that begins a load sequence.
- `busy`  out  1  high while a sequence is running.
- `done`  out  1  one-cycle pulse when the sequence completes.
- `action`  out  4  `pio` action code: NONE=0, INSTR=1, PEND=2, DIV=7, GRPS=5, EN=6.
- `index`  out  5  program slot for INSTR.
- `mindex`  out  2  target machine for PEND, DIV, GRPS and EN.
- `din`  out  32  action data.

## Operation
Register map (write-only):
- 0x00..PROG_DEPTH-1: program word; only `cfg_wdata[15:0]` is stored.
- 0x20 `plen` [5:0].
- 0x21 `en_mask` [NUM_SM-1:0].
- 0x40+4m+0 / +1 / +2: `pend[4:0]` / `div[23:0]` / `grps[31:0]` for machine m.
- Writes to unmapped addresses, or to addresses for m ≥ NUM_SM, are ignored.
- All writes are ignored while `busy`=1.

Reset values:
- `plen`, `en_mask`, `pend`, `div` and `grps` reset to 0.
- Program memory is not reset.

State machine: IDLE → INSTR → CFG → ENA → FIN → IDLE.
- IDLE: `action`=NONE. `start`=1 moves to INSTR with slot counter = 0.
  - The effective length is `plen_eff` = min(`plen`, PROG_DEPTH).
  - If `plen_eff`=0, go directly to CFG.
- INSTR: emits `action`=INSTR, `index`=i, `din`={16'b0, prog[i]} for i = 0..`plen_eff`-1, one per cycle.
- CFG: for each machine m in ascending order with `en_mask[m]`=1, emits three cycles with `mindex`=m:
  - PEND with `din`=`pend`;
  - DIV with `din`=`div`;
  - GRPS with `din`=`grps`.
  - Machines whose mask bit is clear are skipped and take zero cycles.
- ENA: for each enabled machine, in ascending order, emits EN with `mindex`=m and `din`=1, one cycle each. All enables follow all configuration, so machines start within `NUM_SM` cycles of each other.
- FIN: one cycle with `action`=NONE, `done`=1, `busy`=0, then return to IDLE.
- With `en_mask`=0, CFG and ENA take zero cycles.

Output values:
- Unused fields (e.g. `index` outside INSTR, `mindex` in INSTR) are driven 0.
- `din` is 0 whenever `action`=NONE.

## Timing
- All outputs are registered.
- The first action appears in the cycle after the edge that samples `start`=1.
- `busy` rises in that same cycle and stays high through the last non-NONE action.
- Sequence length: `plen_eff` + 4·k cycles of actions, plus 1 FIN cycle, where k = popcount(`en_mask`).
- `start` while busy or in FIN is ignored. There is no queuing and no restart.
- `cfg_we` and `start` in the same IDLE cycle: the write lands first, and the sequence uses the new value.
- Reset mid-sequence: the next cycle shows `action`=NONE, `busy`=0, `done`=0, state IDLE, and config registers cleared. No partial EN is issued after reset.
- Output values under reset: `action`=0, `index`=0, `mindex`=0, `din`=0, `busy`=0, `done`=0.

## Test plan
- Baseline bring-up: program {0xE001, 0x0000}, `plen`=2, `en_mask`=1, `pend[0]`=1, `div[0]`=0x000280, `grps[0]`=0x04000000, pulse `start`.
  - Required: INSTR(0,0xE001), INSTR(1,0x0000), PEND(m0,1), DIV(m0,0x280), GRPS(m0,0x04000000), EN(m0,1) on consecutive cycles.
  - Then `done` pulses; `busy` is high for exactly 6 cycles.
- Multi-machine: `en_mask`=4'b1010, `plen`=0.
  - Required: PEND/DIV/GRPS for m1, then for m3, then EN m1, EN m3; 8 busy cycles; no action carries `mindex` 0 or 2.
- Clamp and ignore: `plen`=40 with PROG_DEPTH=32 → exactly 32 INSTR cycles.
  - A `cfg_we` to 0x40 while busy leaves `pend[0]` unchanged, as shown by a second run.
  - `start` while busy causes no second sequence.
- Empty: `plen`=0, `en_mask`=0, `start` → `done` in the next cycle, `busy` never rises, `action` stays NONE.
- Reset abort: assert `reset`=0 during the third INSTR → `action`=NONE the following cycle, no `done`, no EN.
  - A post-reset `start` with no writes yields an immediate `done`.
- Parameter sweep: NUM_SM=1 with `en_mask` write 0xF → only m0 is configured; writes to 0x44..0x4E are ignored.
